// File: rtl/otter_pipe_stage.sv
// otter_pipe_stage: generic valid/ready inter-stage register with a 2-entry skid buffer.
// Define OTTER_PIPE_PERF_EN to build the stall/bubble performance counters.
module otter_pipe_stage #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int               CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [1:0]       OCCUPANCY,
    input  logic             PERF_CLR,
    output logic [CNT_W-1:0] PERF_STALL_CNT,
    output logic [CNT_W-1:0] PERF_BUBBLE_CNT
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d, s_q, s_d;
    logic             accept, emit;

    // Handshake terms depend only on state and hazard inputs, never on OUT_READY.
    always_comb begin
        IN_READY  = RST & (state_q != FULL) & ~STALL & ~FLUSH;
        OUT_VALID = RST & (state_q != EMPTY) & ~STALL & ~FLUSH;
        OUT_DATA  = OUT_VALID ? m_q : BUBBLE_VALUE;
        OCCUPANCY = RST ? state_q : 2'd0;
        accept    = IN_VALID & IN_READY;
        emit      = OUT_VALID & OUT_READY;
        state_d   = state_q;
        m_d       = m_q;
        s_d       = s_q;
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    m_d     = IN_DATA;
                end
                ONE: if (accept && emit) begin
                    m_d = IN_DATA;
                end else if (accept) begin
                    state_d = FULL;
                    s_d     = IN_DATA;
                end else if (emit) begin
                    state_d = EMPTY;
                end
                FULL: if (emit) begin
                    state_d = ONE;
                    m_d     = s_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= EMPTY;
            m_q     <= BUBBLE_VALUE;
            s_q     <= BUBBLE_VALUE;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

`ifdef OTTER_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d  = PERF_CLR ? '0 : stall_cnt_q + CNT_W'(STALL & ~&stall_cnt_q);
        bubble_cnt_d = PERF_CLR ? '0 : bubble_cnt_q + CNT_W'(OUT_READY & ~OUT_VALID & ~&bubble_cnt_q);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign PERF_STALL_CNT  = stall_cnt_q;
    assign PERF_BUBBLE_CNT = bubble_cnt_q;
`else
    logic perf_clr_unused;
    assign perf_clr_unused = PERF_CLR;
    assign PERF_STALL_CNT  = '0;
    assign PERF_BUBBLE_CNT = '0;
`endif
endmodule

// File: tb/tb_otter_pipe_stage.sv
// tb_otter_pipe_stage: directed scoreboard bench for otter_pipe_stage (WIDTH=32, bubble 0x13, CNT_W=4).
module tb_otter_pipe_stage;
    localparam logic [31:0] BV = 32'h13;

    logic        clk = 0, rst_n = 0, flush = 0, stall = 0, in_valid = 0, out_ready = 1, perf_clr = 0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [3:0]  perf_stall_cnt, perf_bubble_cnt;

    int          passed = 0, total = 0;
    logic [31:0] sb[$];
    logic [3:0]  m_stall = 0, m_bubble = 0;
    logic        accepted;

    otter_pipe_stage #(.WIDTH(32), .BUBBLE_VALUE(32'h13), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst_n), .FLUSH(flush), .STALL(stall),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .OCCUPANCY(occupancy), .PERF_CLR(perf_clr),
        .PERF_STALL_CNT(perf_stall_cnt), .PERF_BUBBLE_CNT(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [3:0] perf(input logic [3:0] v);
`ifdef OTTER_PIPE_PERF_EN
        return v;
`else
        return 4'd0;
`endif
    endfunction

    // One clock: compare outputs mid-cycle against the model, then advance the model past the edge.
    task automatic cycle();
        logic exp_ir, exp_ov;
        @(negedge clk);
        exp_ir = rst_n && sb.size() < 2 && !stall && !flush;
        exp_ov = rst_n && sb.size() > 0 && !stall && !flush;
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        check("out_data", out_data, exp_ov ? sb[0] : BV);
        check("occupancy", {30'b0, occupancy}, rst_n ? sb.size() : 0);
        check("perf_stall", {28'b0, perf_stall_cnt}, {28'b0, perf(m_stall)});
        check("perf_bubble", {28'b0, perf_bubble_cnt}, {28'b0, perf(m_bubble)});
        accepted = in_valid && exp_ir;
        if (!rst_n || flush) sb.delete();
        else begin
            if (exp_ov && out_ready) void'(sb.pop_front());
            if (accepted) sb.push_back(in_data);
        end
        if (!rst_n || perf_clr) begin
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (stall && m_stall != 4'hF) m_stall++;
            if (out_ready && !exp_ov && m_bubble != 4'hF) m_bubble++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_valid = 1;
        in_data = d;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 10);
        if (!accepted) check("send_timeout", d, 32'hFFFF_FFFF);
        in_valid = 0;
    endtask

    initial begin
        repeat (3) cycle();
        rst_n = 1;
        cycle();
        for (int i = 1; i <= 8; i++) send(i);
        repeat (2) cycle();
        out_ready = 0;
        send(32'hA);
        send(32'hB);
        in_valid = 1;
        in_data = 32'hC;
        repeat (2) cycle();
        check("skid_full", {30'b0, occupancy}, 2);
        out_ready = 1;
        send(32'hC);
        repeat (3) cycle();
        out_ready = 0;
        send(32'hA);
        send(32'hB);
        stall = 1;
        repeat (4) cycle();
        check("stall_cnt4", {28'b0, perf_stall_cnt}, {28'b0, perf(4'd4)});
        stall = 0;
        out_ready = 1;
        repeat (3) cycle();
        out_ready = 0;
        send(32'h5);
        flush = 1;
        in_valid = 1;
        in_data = 32'h6;
        cycle();
        flush = 0;
        in_valid = 0;
        out_ready = 1;
        cycle();
        check("flush_empty", {30'b0, occupancy}, 0);
        repeat (2) cycle();
        perf_clr = 1;
        cycle();
        perf_clr = 0;
        repeat (20) cycle();
        check("bubble_sat", {28'b0, perf_bubble_cnt}, {28'b0, perf(4'hF)});
        perf_clr = 1;
        cycle();
        perf_clr = 0;
        cycle();
        out_ready = 0;
        send(32'h77);
        send(32'h88);
        rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        check("reset_mid_empty", {30'b0, occupancy}, 0);
        out_ready = 1;
        send(32'h99);
        repeat (2) cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
